// File: rtl/digit_history_scan.sv
// digit_history_scan: N-deep keypress history, newest in slot 0, scanned onto one shared code bus.
// Optional macro DIGIT_HISTORY_BLANK_EN darkens digits whose history slot is not yet filled.
module digit_history_scan #(
  parameter int NUM_DIGITS  = 2,
  parameter int CODE_W      = 8,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                            int_osc,
  input  logic                            reset,
  input  logic                            key_valid,
  input  logic [CODE_W-1:0]               key_code,
  input  logic                            clear,
  output logic [NUM_DIGITS-1:0]           digit_en,
  output logic [CODE_W-1:0]               seg_code,
  output logic [$clog2(NUM_DIGITS+1)-1:0] fill
);

  localparam int FILL_W = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(NUM_DIGITS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);

  logic [CODE_W-1:0] hist_q [NUM_DIGITS];
  logic [CODE_W-1:0] hist_d [NUM_DIGITS];
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              rcnt_last;
  logic              slot_blank;

  // Clear has priority over a simultaneous strobe; the strobed key is dropped.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hist_d[i] = hist_q[i];
    end
    fill_d = fill_q;
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist_d[i] = '0;
      end
      fill_d = '0;
    end else if (key_valid) begin
      hist_d[0] = key_code;
      for (int i = 1; i < NUM_DIGITS; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // Refresh/scan runs free of pushes and clears.
  always_comb begin
    rcnt_last = (rcnt_q == RCNT_LAST);
    rcnt_d    = rcnt_last ? '0 : rcnt_q + RCNT_W'(1);
    idx_d     = idx_q;
    if (rcnt_last) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist_q[i] <= '0;
      end
      fill_q <= '0;
      idx_q  <= '0;
      rcnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist_q[i] <= hist_d[i];
      end
      fill_q <= fill_d;
      idx_q  <= idx_d;
      rcnt_q <= rcnt_d;
    end
  end

  always_comb begin
`ifdef DIGIT_HISTORY_BLANK_EN
    slot_blank = (32'(idx_q) >= 32'(fill_q));
`else
    slot_blank = 1'b0;
`endif
    digit_en = '0;
    seg_code = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((idx_q == IDX_W'(i)) && !slot_blank) begin
        digit_en[i] = 1'b1;
        seg_code    = hist_q[i];
      end
    end
  end

  assign fill = fill_q;

endmodule

// File: tb/tb_digit_history_scan.sv
// Bench for digit_history_scan: fixed vector table, hand sequences and a queue-based random model.
// Expectations follow DIGIT_HISTORY_BLANK_EN when the bench is built with it.
module tb_digit_history_scan;

  logic       clk = 1'b0;
  logic       rst, kv, clr;
  logic [7:0] kc;
  logic [3:0] en4;
  logic [7:0] seg4;
  logic [2:0] fill4;

  logic       rst3, kv3, clr3;
  logic [7:0] kc3;
  logic [2:0] en3;
  logic [7:0] seg3;
  logic [1:0] fill3;

  int vectors = 0;
  int miscompares = 0;

  digit_history_scan #(.NUM_DIGITS(4), .CODE_W(8), .REFRESH_DIV(4)) u_dut (
    .int_osc(clk), .reset(rst), .key_valid(kv), .key_code(kc), .clear(clr),
    .digit_en(en4), .seg_code(seg4), .fill(fill4)
  );

  digit_history_scan #(.NUM_DIGITS(3), .CODE_W(8), .REFRESH_DIV(1)) u_dut3 (
    .int_osc(clk), .reset(rst3), .key_valid(kv3), .key_code(kc3), .clear(clr3),
    .digit_en(en3), .seg_code(seg3), .fill(fill3)
  );

  always #5 clk = ~clk;

  // Reference model: history as a newest-first queue, scan position from elapsed cycles.
  logic [7:0] mq [$];
  int t;

  function automatic logic blank_on();
`ifdef DIGIT_HISTORY_BLANK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_exp(output logic [3:0] e, output logic [7:0] s, output logic [2:0] f);
    int i;
    i = (t / 4) % 4;
    f = 3'(mq.size());
    e = 4'(1 << i);
    s = (i < mq.size()) ? mq[i] : 8'h00;
    if (blank_on() && i >= mq.size()) begin
      e = 4'b0000;
      s = 8'h00;
    end
  endtask

  task automatic check(string name, logic [3:0] ge, logic [7:0] gs, logic [2:0] gf,
                       logic [3:0] we, logic [7:0] ws, logic [2:0] wf);
    vectors++;
    if (ge !== we || gs !== ws || gf !== wf) begin
      miscompares++;
      $display("FAIL %s: got en=%b seg=%h fill=%0d, want en=%b seg=%h fill=%0d",
               name, ge, gs, gf, we, ws, wf);
    end
  endtask

  task automatic check_model(string name);
    logic [3:0] e; logic [7:0] s; logic [2:0] f;
    model_exp(e, s, f);
    check(name, en4, seg4, fill4, e, s, f);
  endtask

  // Inputs are driven at the falling edge, sampled at the rising edge, checked at the next fall.
  task automatic cycle(logic v, logic [7:0] c, logic cl, string name);
    kv = v; kc = c; clr = cl;
    @(posedge clk);
    if (cl) mq.delete();
    else if (v) begin
      mq.push_front(c);
      if (mq.size() > 4) void'(mq.pop_back());
    end
    t++;
    @(negedge clk);
    kv = 1'b0; clr = 1'b0;
    check_model(name);
  endtask

  // Assert reset between edges, check outputs before the next edge, release on a falling edge.
  task automatic pulse_reset(string name);
    #2 rst = 1'b1;
    #1 check(name, en4, seg4, fill4, blank_on() ? 4'b0000 : 4'b0001, 8'h00, 3'd0);
    mq.delete();
    t = 0;
    @(negedge clk);
    rst = 1'b0;
    check_model({name, "_rel"});
  endtask

  typedef struct {
    logic       v;
    logic [7:0] c;
    logic       cl;
    logic [3:0] en;
    logic [7:0] seg;
    logic [2:0] f;
  } vec_t;

  vec_t tbl [20];

  initial begin
    rst = 1'b1; kv = 1'b0; kc = 8'h00; clr = 1'b0;
    rst3 = 1'b1; kv3 = 1'b0; kc3 = 8'h00; clr3 = 1'b0;

    tbl[0]  = '{1'b1, 8'h11, 1'b0, 4'b0001, 8'h11, 3'd1};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 4'b0001, 8'h22, 3'd2};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 4'b0001, 8'h33, 3'd3};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 4'b0010, 8'h33, 3'd4};
    tbl[4]  = '{1'b1, 8'h55, 1'b0, 4'b0010, 8'h44, 3'd4};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 4'b0010, 8'h44, 3'd4};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 4'b0010, 8'h44, 3'd4};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 4'b0100, 8'h33, 3'd4};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 4'b0100, 8'h33, 3'd4};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 4'b0100, 8'h33, 3'd4};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 4'b0100, 8'h33, 3'd4};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 4'b1000, 8'h22, 3'd4};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 4'b1000, 8'h22, 3'd4};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 4'b1000, 8'h22, 3'd4};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 4'b1000, 8'h22, 3'd4};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 4'b0001, 8'h55, 3'd4};
    tbl[16] = '{1'b1, 8'h99, 1'b1, 4'b0001, 8'h00, 3'd0};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 4'b0001, 8'h00, 3'd0};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 4'b0001, 8'h00, 3'd0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 4'b0010, 8'h00, 3'd0};

    // NUM_DIGITS=3, REFRESH_DIV=1 corner: idx advances every edge.
    @(negedge clk);
    check("dut3_reset", {1'b0, en3}, seg3, {1'b0, fill3},
          blank_on() ? 4'b0000 : 4'b0001, 8'h00, 3'd0);
    rst3 = 1'b0;
    kv3 = 1'b1; kc3 = 8'hA1;
    @(negedge clk);
    kc3 = 8'hB2;
    @(negedge clk);
    kv3 = 1'b0;
    check("dut3_e2", {1'b0, en3}, seg3, {1'b0, fill3},
          blank_on() ? 4'b0000 : 4'b0100, 8'h00, 3'd2);
    @(negedge clk);
    check("dut3_e3", {1'b0, en3}, seg3, {1'b0, fill3}, 4'b0001, 8'hB2, 3'd2);
    @(negedge clk);
    check("dut3_e4", {1'b0, en3}, seg3, {1'b0, fill3}, 4'b0010, 8'hA1, 3'd2);
    @(negedge clk);
    check("dut3_e5", {1'b0, en3}, seg3, {1'b0, fill3},
          blank_on() ? 4'b0000 : 4'b0100, 8'h00, 3'd2);
    @(negedge clk);
    check("dut3_e6", {1'b0, en3}, seg3, {1'b0, fill3}, 4'b0001, 8'hB2, 3'd2);

    // Reset values, then 16 idle cycles of scan order.
    check("reset_val", en4, seg4, fill4, blank_on() ? 4'b0000 : 4'b0001, 8'h00, 3'd0);
    rst = 1'b0;
    mq.delete();
    t = 0;
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b0, "idle_scan");

    // Table: push order, overflow, frame readback, clear beating a key.
    pulse_reset("reset_tbl");
    for (int i = 0; i < 20; i++) begin
      logic [3:0] we;
      kv = tbl[i].v; kc = tbl[i].c; clr = tbl[i].cl;
      @(negedge clk);
      kv = 1'b0; clr = 1'b0;
      we = tbl[i].en;
      if (blank_on() && tbl[i].f == 3'd0) we = 4'b0000;
      check($sformatf("tbl_%0d", i), en4, seg4, fill4, we, tbl[i].seg, tbl[i].f);
    end

    // Single key then a full frame: blanking shows only digit 0 when enabled.
    pulse_reset("reset_blank");
    cycle(1'b1, 8'h3F, 1'b0, "blank_push");
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b0, "blank_frame");

    // Async reset mid-dwell with fill=3, idx=2, rcnt=1.
    pulse_reset("reset_pre");
    cycle(1'b1, 8'h0A, 1'b0, "mid_push");
    cycle(1'b1, 8'h0B, 1'b0, "mid_push");
    cycle(1'b1, 8'h0C, 1'b0, "mid_push");
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, "mid_idle");
    pulse_reset("reset_mid");
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, "post_reset_dwell");

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r == 0) pulse_reset("rnd_reset");
      else cycle($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 99) < 4, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/digit_history_scan.md
# digit_history_scan

Parameterised keypad-entry history and multiplexed display scanner. Each accepted keypress is pushed into an N-deep history, with slot 0 holding the newest entry and slot N-1 the oldest. A free-running internal refresh counter scans the history onto one shared segment/code bus with a one-hot digit enable. The block sits between the keypad decoder/debouncer (which supplies a one-cycle key strobe) and the seven-segment decode/anode drivers, and generalises the fixed two-digit current/past display controller.

## Interface
Parameters:
- NUM_DIGITS, default 2: history depth and number of multiplexed digits; must be ≥1.
- CODE_W, default 8: width of a stored key code.
- REFRESH_DIV, default 1000: clock cycles each digit stays enabled; must be ≥1.

Ports:
- int_osc, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: reset, asynchronous, active-high.
- key_valid, input, 1: one-cycle strobe; `key_code` is pushed on every cycle it is high.
- key_code, input, CODE_W: key code to push.
- clear, input, 1: synchronous flush of the history.
- digit_en, output, NUM_DIGITS: one-hot, active-high digit enable; bit i drives history slot i.
- seg_code, output, CODE_W: code of the slot currently being scanned.
- fill, output, $clog2(NUM_DIGITS+1): number of valid history entries.

## Operation
- **State:** history array `hist[0..NUM_DIGITS-1]` (CODE_W each), `fill` counter, scan index `idx` (0..NUM_DIGITS-1), refresh counter `rcnt` (0..REFRESH_DIV-1).
- **Reset:** all `hist` = 0, `fill` = 0, `idx` = 0, `rcnt` = 0.
- **Push (key_valid=1, clear=0):**
  - `hist[i] <= hist[i-1]` for i≥1, and `hist[0] <= key_code`.
  - The oldest entry is discarded.
  - `fill` increments and saturates at NUM_DIGITS.
  - Back-to-back strobes each push; no strobe is dropped.
- **Clear (clear=1):** all `hist` <= 0, `fill` <= 0.
  - Clear wins over a simultaneous key_valid; that key is lost.
  - Clear does not affect `idx` or `rcnt`.
- **Scan, running independently of pushes and clears:**
  - `rcnt` counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the cycle `rcnt` == REFRESH_DIV-1, `idx` advances by one, wrapping from NUM_DIGITS-1 to 0.
  - With NUM_DIGITS=1, `idx` stays 0.
- **Output decode:**
  - Outputs are combinational from registered state only; key inputs never reach the outputs combinationally.
  - `digit_en` = one-hot(`idx`); `seg_code` = `hist[idx]`.
  - At most one `digit_en` bit is high in any cycle.
- **Unused slots:** behaviour depends on DIGIT_HISTORY_BLANK_EN (see Configuration).

## Timing
- **Push latency:** a push sampled at edge k appears in `hist` and `fill` immediately after edge k. If `idx` = 0, `seg_code` shows the new code in the same post-edge cycle.
- **Scan period:**
  - Each digit is enabled for exactly REFRESH_DIV consecutive cycles.
  - A full frame lasts NUM_DIGITS×REFRESH_DIV cycles.
  - `idx` and `digit_en` change together; there is no overlap cycle and no dead cycle.
- **Reset values:**
  - Without the macro: `digit_en` = 1 (bit 0), `seg_code` = 0, `fill` = 0.
  - With the macro: `digit_en` = 0, `seg_code` = 0, `fill` = 0.
- **Reset mid-operation:** asynchronous assertion immediately forces all reset values, including mid-frame and mid-push. After deassertion, scanning restarts at digit 0 with a full REFRESH_DIV dwell.
- **Width rules:**
  - `fill` never exceeds NUM_DIGITS.
  - `idx` is compared against NUM_DIGITS-1 explicitly, so the wrap is correct for non-power-of-two NUM_DIGITS.
  - `rcnt` uses width $clog2(REFRESH_DIV) with a minimum of 1.

## Configuration
- Macro: DIGIT_HISTORY_BLANK_EN.
- **Defined:**
  - While `idx` ≥ `fill` (an unfilled slot), `digit_en` = 0 and `seg_code` = 0 for that dwell period.
  - The scan timing is unchanged; the slot still occupies REFRESH_DIV cycles.
  - After reset or clear, all digits are dark until keys arrive.
- **Undefined:**
  - Unfilled slots are scanned normally; `digit_en` is driven and `seg_code` shows the stored 0.
  - The `fill` output still exists and counts identically.

## Test plan
All scenarios use NUM_DIGITS=4, CODE_W=8, REFRESH_DIV=4.

1. **Reset and scan order:** assert reset, release it, and idle for 16 cycles. Expect `digit_en` to step 0001→0010→0100→1000→0001 every 4 cycles, `seg_code` = 0, and `fill` = 0. With the macro defined, expect `digit_en` to stay 0000 throughout.
2. **Push order and overflow:** strobe codes 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles. Expect `hist[0..3]` = 0x55, 0x44, 0x33, 0x22, `fill` = 4 (saturated), and 0x11 discarded. Over one frame, `seg_code` reads 0x55, 0x44, 0x33, 0x22 in digit order.
3. **Clear with simultaneous key:** with the history full, assert `clear` and `key_valid` (0x99) in the same cycle. Expect all slots = 0, `fill` = 0, and 0x99 absent. Expect `idx` to keep stepping without restart.
4. **Blanking:** with the macro defined, push a single 0x3F. Expect digit 0 enabled showing 0x3F for 4 cycles, then 12 cycles of `digit_en` = 0000 and `seg_code` = 0.
5. **Async reset mid-dwell:** with `fill` = 3 and `idx` = 2, at `rcnt` = 1, pulse reset between clock edges. Expect outputs to go to their reset values before the next edge. Afterwards, expect digit 0 to hold a full 4 cycles.
6. **Parameter corner:** with NUM_DIGITS=3 and REFRESH_DIV=1, push 0xA1, 0xB2. Expect `digit_en` to cycle 001→010→100→001 every cycle, `seg_code` = 0xB2, 0xA1, 0x00, and `fill` = 2.
